// File: rtl/led_matrix_pkg.sv
// Shared constants for the LED matrix scan driver: register offsets, CTRL bits, geometry.
package led_matrix_pkg;
  localparam int NUM_ROWS = 8;

  localparam logic [7:0] ROW0_OFS  = 8'd0;
  localparam logic [7:0] CTRL_OFS  = 8'd8;
  localparam logic [7:0] FRAME_OFS = 8'd9;

  localparam int CTRL_SWAP_BIT = 0;
  localparam int CTRL_EN_BIT   = 1;

  function automatic logic [7:0] row_onehot(input logic [2:0] row);
    return 8'b1 << row;
  endfunction
endpackage

// File: rtl/led_scan_timer.sv
// Row-slot prescaler and row counter; exposes next-cycle row/blank state so the
// parent can register its outputs aligned to the slot. No backpressure, free-running.
module led_scan_timer import led_matrix_pkg::*; #(
  parameter int ROW_CYCLES   = 2500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic [2:0] o_row_nxt,
  output logic       o_blank_nxt,
  output logic       o_frame_end
);
  localparam int            PW       = $clog2(ROW_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(ROW_CYCLES - 1);

  logic [PW-1:0] r_pre;
  logic [2:0]    r_row;
  logic          w_pre_last;
  logic [PW-1:0] w_pre_nxt;

  assign w_pre_last  = (r_pre == PRE_LAST);
  assign w_pre_nxt   = w_pre_last ? '0 : r_pre + 1'b1;
  assign o_row_nxt   = w_pre_last ? r_row + 3'd1 : r_row;
  assign o_blank_nxt = (int'(w_pre_nxt) < BLANK_CYCLES);
  assign o_frame_end = w_pre_last && (r_row == 3'(NUM_ROWS - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pre <= '0;
      r_row <= '0;
    end else begin
      r_pre <= w_pre_nxt;
      r_row <= o_row_nxt;
    end
  end
endmodule

// File: rtl/led_matrix_driver.sv
// Memory-mapped 8x8 LED matrix scan driver; all outputs registered, rd_data one cycle after rd_en.
// LED_MATRIX_DOUBLE_BUFFER_EN adds a back buffer with frame-aligned swap; otherwise one shared buffer.
module led_matrix_driver import led_matrix_pkg::*; #(
  parameter int         ROW_CYCLES   = 2500,
  parameter int         BLANK_CYCLES = 16,
  parameter logic [7:0] BASE_ADDR    = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [7:0] io_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic [7:0] led_x,
  output logic [7:0] led_y
);
  logic [7:0] w_ofs;
  logic       w_is_row, w_is_ctrl, w_is_frame;
  logic [2:0] w_row_idx;
  logic       w_wr_row, w_wr_ctrl, w_wr_hit;
  logic [2:0] w_row_nxt;
  logic       w_blank_nxt, w_frame_end;
  logic       w_en_nxt;
  logic [7:0] w_back_rd, w_front_nxt, w_rd_mux;
  logic       w_pending;
  logic       r_en;
  logic [7:0] r_frame;

  assign w_ofs      = io_addr - BASE_ADDR;
  assign w_is_row   = (w_ofs < CTRL_OFS);
  assign w_is_ctrl  = (w_ofs == CTRL_OFS);
  assign w_is_frame = (w_ofs == FRAME_OFS);
  assign w_row_idx  = 3'(w_ofs - ROW0_OFS);
  assign w_wr_row   = wr_en & w_is_row;
  assign w_wr_ctrl  = wr_en & w_is_ctrl;
  assign w_en_nxt   = w_wr_ctrl ? wr_data[CTRL_EN_BIT] : r_en;
  // A write landing on the row about to be shown must be forwarded to the output register.
  assign w_wr_hit   = w_wr_row && (w_row_idx == w_row_nxt);

  led_scan_timer #(
    .ROW_CYCLES  (ROW_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .i_clk      (clk),
    .i_reset    (reset),
    .o_row_nxt  (w_row_nxt),
    .o_blank_nxt(w_blank_nxt),
    .o_frame_end(w_frame_end)
  );

`ifdef LED_MATRIX_DOUBLE_BUFFER_EN
  logic [7:0] r_buf_a [NUM_ROWS];
  logic [7:0] r_buf_b [NUM_ROWS];
  logic       r_front_b;
  logic       r_pending;
  logic       w_swap, w_swap_req;
  logic [7:0] w_a_nxt, w_b_nxt;

  assign w_swap_req = w_wr_ctrl & wr_data[CTRL_SWAP_BIT];
  assign w_swap     = r_pending & w_frame_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        r_buf_a[i] <= '0;
        r_buf_b[i] <= '0;
      end
      r_front_b <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_wr_row) begin
        if (r_front_b) r_buf_a[w_row_idx] <= wr_data;
        else           r_buf_b[w_row_idx] <= wr_data;
      end
      if (w_swap) r_front_b <= ~r_front_b;
      // A request on the boundary cycle re-arms for the following boundary.
      r_pending <= (r_pending & ~w_frame_end) | w_swap_req;
    end
  end

  assign w_back_rd   = r_front_b ? r_buf_a[w_row_idx] : r_buf_b[w_row_idx];
  assign w_a_nxt     = (w_wr_hit &  r_front_b) ? wr_data : r_buf_a[w_row_nxt];
  assign w_b_nxt     = (w_wr_hit & ~r_front_b) ? wr_data : r_buf_b[w_row_nxt];
  assign w_front_nxt = (r_front_b ^ w_swap) ? w_b_nxt : w_a_nxt;
  assign w_pending   = r_pending;
`else
  logic [7:0] r_buf [NUM_ROWS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ROWS; i++) r_buf[i] <= '0;
    end else if (w_wr_row) begin
      r_buf[w_row_idx] <= wr_data;
    end
  end

  assign w_back_rd   = r_buf[w_row_idx];
  assign w_front_nxt = w_wr_hit ? wr_data : r_buf[w_row_nxt];
  assign w_pending   = 1'b0;
`endif

  always_comb begin
    w_rd_mux = 8'h00;
    if (w_is_row) begin
      w_rd_mux = w_back_rd;
    end else if (w_is_ctrl) begin
      w_rd_mux[CTRL_EN_BIT]   = r_en;
      w_rd_mux[CTRL_SWAP_BIT] = w_pending;
    end else if (w_is_frame) begin
      w_rd_mux = r_frame;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en    <= 1'b0;
      r_frame <= 8'h00;
      led_x   <= 8'h00;
      led_y   <= 8'h00;
      rd_data <= 8'h00;
    end else begin
      r_en <= w_en_nxt;
      if (w_frame_end) r_frame <= r_frame + 8'd1;
      if (w_en_nxt && !w_blank_nxt) begin
        led_x <= w_front_nxt;
        led_y <= row_onehot(w_row_nxt);
      end else begin
        led_x <= 8'h00;
        led_y <= 8'h00;
      end
      rd_data <= rd_en ? w_rd_mux : 8'h00;
    end
  end
endmodule

// File: tb/tb_led_matrix_driver.sv
// Randomised and directed bench for led_matrix_driver with a cycle-count reference model and output scoreboard.
module tb_led_matrix_driver;
  localparam int         RC   = 8;
  localparam int         BC   = 2;
  localparam int         FR   = 8 * RC;
  localparam logic [7:0] BASE = 8'h10;
`ifdef LED_MATRIX_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] io_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data, led_x, led_y;

  led_matrix_driver #(
    .ROW_CYCLES  (RC),
    .BLANK_CYCLES(BC),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .io_addr(io_addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .led_x  (led_x),
    .led_y  (led_y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] rd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: state as of cycle m_t (cycles since reset released).
  int         m_t = 0;
  logic [7:0] fb [2][8];
  bit         m_fi, m_en, m_pend, m_req, m_bnd, m_bi;
  logic [7:0] m_frame, m_ofs;
  exp_t       m_e;
  int         m_pos, m_row;

  always @(posedge clk) begin
    m_e = '0;
    if (reset) begin
      m_t = 0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++) fb[b][r] = 8'h00;
      m_fi = 0; m_en = 0; m_pend = 0; m_frame = 8'h00;
    end else begin
      m_bi  = DB ? ~m_fi : m_fi;
      m_ofs = io_addr - BASE;
      if (rd_en) begin
        if (m_ofs < 8)       m_e.rd = fb[m_bi][m_ofs[2:0]];
        else if (m_ofs == 8) m_e.rd = {6'b0, m_en, m_pend};
        else if (m_ofs == 9) m_e.rd = m_frame;
      end
      m_req = 0;
      if (wr_en) begin
        if (m_ofs < 8) fb[m_bi][m_ofs[2:0]] = wr_data;
        else if (m_ofs == 8) begin
          m_en  = wr_data[1];
          m_req = DB && wr_data[0];
        end
      end
      m_bnd = ((m_t % FR) == FR - 1);
      if (m_bnd) begin
        m_frame = m_frame + 8'd1;
        if (m_pend) m_fi = ~m_fi;
      end
      m_pend = (m_pend && !m_bnd) || m_req;
      m_t++;
      m_pos = m_t % RC;
      m_row = (m_t / RC) % 8;
      if (m_en && m_pos >= BC) begin
        m_e.x = fb[m_fi][m_row];
        m_e.y = 8'(1 << m_row);
      end
    end
    q.push_back(m_e);
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0d", nm, act, want, m_t);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("led_x", led_x, mon_e.x);
      chk("led_y", led_y, mon_e.y);
      chk("rd_data", rd_data, mon_e.rd);
    end
  end

  task automatic io(input bit we, input bit re, input logic [7:0] a, input logic [7:0] d);
    wr_en = we; rd_en = re; io_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while ((m_t % FR) != p && n < 4 * FR) begin
      @(negedge clk);
      n++;
    end
    if ((m_t % FR) != p) begin
      total++;
      bad++;
      $display("FAIL wait_pos got=%0d want=%0d", m_t % FR, p);
    end
  endtask

  logic [2:0] rnd;
  logic [7:0] ra, rdat;

  initial begin
    // Reset, display disabled for a full frame, then FRAME should read 1.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(64);
    io(0, 1, BASE + 8'd9, 8'h00);

    // Row 2 pattern with enable and swap.
    io(1, 0, BASE + 8'd2, 8'hA5);
    io(1, 0, BASE + 8'd8, 8'h03);
    wait_pos(FR - 1);
    idle(FR + 4);
    io(1, 1, BASE + 8'd2, 8'h77);
    io(0, 1, BASE + 8'd2, 8'h00);

    // Swap request exactly on the boundary cycle waits one full frame.
    wait_pos(FR - 1);
    io(1, 0, BASE + 8'd8, 8'h03);
    for (int i = 0; i < 4; i++) begin
      io(0, 1, BASE + 8'd8, 8'h00);
      idle(14);
    end
    // Row 0 write on the commit cycle goes to the new front buffer.
    wait_pos(FR - 1);
    io(1, 0, BASE + 8'd0, 8'h3C);
    io(0, 1, BASE + 8'd8, 8'h00);
    idle(FR + 4);

    // Single-row bitmap on row 7, enable only.
    io(1, 0, BASE + 8'd7, 8'hFF);
    io(1, 0, BASE + 8'd8, 8'h02);
    io(0, 1, BASE + 8'd8, 8'h00);
    idle(2 * FR);

    // Random traffic across and just outside the register window.
    for (int i = 0; i < 1500; i++) begin
      rnd  = 3'($urandom_range(0, 7));
      ra   = BASE - 8'd2 + 8'($urandom_range(0, 13));
      rdat = 8'($urandom);
      if (ra == BASE + 8'd8 && $urandom_range(0, 3) != 0) rdat[1] = 1'b1;
      io(rnd[0], rnd[1], ra, rdat);
    end

    // Reset in the middle of row 5 with a swap pending.
    io(1, 0, BASE + 8'd4, 8'h99);
    wait_pos(20);
    io(1, 0, BASE + 8'd8, 8'h03);
    wait_pos(42);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) io(0, 1, BASE + 8'(i), 8'h00);
    io(1, 0, BASE + 8'd8, 8'h02);
    idle(FR + 4);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_matrix_driver.md
# led_matrix_driver

Memory-mapped 8×8 LED matrix scan driver that sits on the CPU I/O path, downstream of the CPU/RAM core, and drives `led_x`/`led_y` at the top level. The CPU writes row bitmaps into a framebuffer via I/O writes. The block multiplexes one row at a time onto the matrix, with blanking between rows, and exposes a frame counter the game uses as its tick. With double buffering compiled in, the CPU draws into a back buffer and requests a swap that lands on a frame boundary.

## Interface
- `ROW_CYCLES`, default 2500: clock cycles per row slot; must be ≥ 2.
- `BLANK_CYCLES`, default 16: leading cycles of each row slot with outputs dark; must satisfy 0 ≤ BLANK_CYCLES < ROW_CYCLES.
- `BASE_ADDR`, default 8'h10: I/O base address; occupies BASE_ADDR..BASE_ADDR+9.
- `clk` input 1: system clock.
- `reset` input 1: reset, synchronous, active-high.
- `wr_en` input 1: I/O write strobe, one cycle per write.
- `rd_en` input 1: I/O read strobe.
- `io_addr` input 8: I/O address.
- `wr_data` input 8: write data.
- `rd_data` output 8: registered read data.
- `led_x` output 8: column pattern, active-high, bit n = column n.
- `led_y` output 8: row select, one-hot active-high, bit r = row r.

## Operation
- Address map, as offsets from BASE_ADDR:
  - 0–7 (R/W): framebuffer row 0–7.
  - 8 CTRL: write bit0 = swap request, bit1 = display enable; read bit0 = swap pending, bit1 = enable.
  - 9 FRAME (RO): 8-bit frame counter.
- Writes to offset 9 or to unmapped addresses are ignored. Reads of unmapped addresses return 8'h00.
- Framebuffer writes and reads always target the back buffer.
- Scan sequence: row counter 0→7, then wraps to 0. Each row slot lasts ROW_CYCLES cycles.
  - Blank phase: the first BLANK_CYCLES cycles of each slot drive `led_x`=0 and `led_y`=0.
  - Active phase: the remainder of the slot drives `led_x`=front[row] and `led_y`=1<<row.
- When enable=0: scanning and the frame counter keep running, but `led_x`/`led_y` are forced to 0.
- Frame boundary: the last cycle of row 7's slot.
  - FRAME increments at the boundary, wrapping 255→0.
  - If swap pending is set at the boundary, the front/back buffers exchange and pending clears.
- A swap request while already pending has no extra effect.
- A swap request arriving on the boundary cycle itself sets pending and waits for the next boundary.
- A row write and a swap in the same cycle: the write lands in the pre-swap back buffer, which is the new front buffer.
- Reset clears:
  - both buffers to 8'h00, so the front buffer is also 0x00;
  - row counter, prescaler, FRAME, pending and enable to 0;
  - `led_x`, `led_y` and `rd_data` to 8'h00.
- Reset asserted mid-frame abandons the swap and scan immediately.

## Timing
- All outputs are registered.
- `rd_data` is valid the cycle after `rd_en` and reads 8'h00 in every other cycle.
- A read in the same cycle as a write to that location returns the old value.
- Row slot r of frame f starts ROW_CYCLES·(8f+r) cycles after reset deasserts.
- The first active `led_y`=8'h01 appears BLANK_CYCLES cycles after that slot start (when enable=1).
- A swap becomes visible at row 0 of the frame following the boundary.
- Worst-case swap latency is 8·ROW_CYCLES cycles.
- Enable changes take effect on outputs the cycle after the write.

## Configuration
- `LED_MATRIX_DOUBLE_BUFFER_EN` defined:
  - two 8×8 buffers, swap mechanism as described.
- `LED_MATRIX_DOUBLE_BUFFER_EN` undefined:
  - a single buffer is both front and back, so writes show on the next active phase of that row;
  - CTRL bit0 writes are ignored and pending always reads 0;
  - the FRAME counter is unchanged.

## Structure
- Package `led_matrix_pkg` holds:
  - address offsets (ROW0_OFS=0, CTRL_OFS=8, FRAME_OFS=9);
  - CTRL bit positions;
  - NUM_ROWS=8.
- Sub-module `led_scan_timer` contains the prescaler, row counter, blank flag and frame-boundary pulse.
- The top of this block holds the buffers, register file and output muxing.

## Test plan
All scenarios use ROW_CYCLES=8, BLANK_CYCLES=2, BASE_ADDR=8'h10.
- Reset for 3 cycles, release, enable=0 → `led_x`/`led_y`/`rd_data` stay 8'h00 for 64 cycles; FRAME reads 8'h01 after 64 cycles.
- Write 8'hA5 to 0x12, CTRL=8'h03 → from the next boundary, in row slot 2, cycles 2–7 show `led_y`=8'h04, `led_x`=8'hA5, while cycles 0–1 are dark.
- Issue a swap request on the boundary cycle → pending reads 1 for one more full frame, then clears, and the swap lands at that later boundary.
- Write 8'h3C to 0x10 on the same cycle the swap commits → 8'h3C is displayed in row 0 of the next frame.
- Assert reset mid-row 5 with a swap pending → all outputs, FRAME and pending go to 0 the next cycle, and both buffers read 8'h00.
- Without `LED_MATRIX_DOUBLE_BUFFER_EN`: write 8'hFF to 0x17 with enable=1 → shown in the next row-7 active phase, and CTRL bit0 reads 0.
